// File: rtl/uart_cmd_host.sv
// uart_cmd_host: serializes one host request into UART command frames and
// assembles the response bytes (with an inter-byte timeout) into rsp_data.
module uart_cmd_host #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_cmd,
    input  logic [RF_ADDR-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH-1:0]     req_op_a,
    input  logic [DATA_WIDTH-1:0]     req_op_b,
    input  logic [3:0]                req_fun,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rsp_valid,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_ALU = 2'b10;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cmd_q;
    logic [RF_ADDR-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]   data_q, op_a_q, op_b_q;
    logic [3:0]              fun_q;
    logic [1:0]              idx_q, idx_d, rcnt_q, rcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    tflag_q, tflag_d;
    logic [2*DATA_WIDTH-1:0] buf_q, buf_d, rsp_q, rsp_d;
    logic [1:0]              last_idx, exp_bytes;
    logic [DATA_WIDTH-1:0]   hdr, frame, fun_byte, addr_byte;
    logic                    accept, expired;

    assign fun_byte  = DATA_WIDTH'(fun_q);
    assign addr_byte = DATA_WIDTH'(addr_q);
    assign hdr = cmd_q == CMD_WR  ? DATA_WIDTH'(8'hAA) :
                 cmd_q == CMD_RD  ? DATA_WIDTH'(8'hBB) :
                 cmd_q == CMD_ALU ? DATA_WIDTH'(8'hCC) : DATA_WIDTH'(8'hDD);
    assign frame = idx_q == 2'd0 ? hdr :
                   idx_q == 2'd1 ? (cmd_q[1] ? (cmd_q[0] ? fun_byte : op_a_q) : addr_byte) :
                   idx_q == 2'd2 ? (cmd_q[1] ? op_b_q : data_q) : fun_byte;
    assign last_idx  = cmd_q == CMD_WR ? 2'd2 : cmd_q == CMD_ALU ? 2'd3 : 2'd1;
    assign exp_bytes = cmd_q == CMD_WR ? 2'd0 : cmd_q == CMD_RD ? 2'd1 : 2'd2;
    // Expire when the counter would step onto TIMEOUT_CYCLES-1, so DONE lands
    // exactly TIMEOUT_CYCLES cycles after the last byte.
    assign expired = tcnt_q == TW'(TIMEOUT_CYCLES - 2);

    assign req_ready   = state_q == IDLE;
    assign accept      = req_valid && req_ready;
    assign tx_valid    = state_q == SEND;
    assign tx_data     = tx_valid ? frame : '0;
    assign rsp_valid   = state_q == DONE;
    assign rsp_timeout = rsp_valid && tflag_q;
    assign rsp_data    = rsp_q;
    assign busy        = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        tflag_d = tflag_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                state_d = SEND;
                idx_d   = '0;
                buf_d   = '0;
                tflag_d = 1'b0;
            end
            SEND: if (tx_ready) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx) begin
                    state_d = cmd_q == CMD_WR ? DONE : WAIT_RSP;
                    rcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            WAIT_RSP: if (rx_valid) begin
                // An arriving byte always wins over a simultaneous expiry.
                rcnt_d = rcnt_q + 2'd1;
                tcnt_d = '0;
                if (rcnt_q == 2'd0) buf_d[DATA_WIDTH-1:0] = rx_data;
                else buf_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_data;
                if (rcnt_q + 2'd1 == exp_bytes) state_d = DONE;
            end else if (expired) begin
                state_d = DONE;
                tflag_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
            DONE: state_d = IDLE;
        endcase
        rsp_d = state_d == DONE ? buf_d : rsp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            fun_q   <= '0;
            idx_q   <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
            buf_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_d;
            buf_q   <= buf_d;
            rsp_q   <= rsp_d;
            if (accept) begin
                cmd_q  <= req_cmd;
                addr_q <= req_addr;
                data_q <= req_data;
                op_a_q <= req_op_a;
                op_b_q <= req_op_b;
                fun_q  <= req_fun;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_host.sv
// tb_uart_cmd_host: directed table plus randomized transactions checked
// against a frame/response model derived from the command protocol rules.
module tb_uart_cmd_host;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [1:0] req_cmd = '0;
    logic [3:0] req_addr = '0, req_fun = '0;
    logic [7:0] req_data = '0, req_op_a = '0, req_op_b = '0;
    logic [7:0] tx_data, rx_data = '0;
    logic tx_valid, tx_ready = 1'b1, rx_valid = 1'b0;
    logic rsp_valid, rsp_timeout, busy;
    logic [15:0] rsp_data;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_cmd_host #(.DATA_WIDTH(8), .RF_ADDR(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_op_a(req_op_a),
        .req_op_b(req_op_b), .req_fun(req_fun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    typedef struct packed {
        logic [1:0]  cmd;
        logic [3:0]  addr;
        logic [7:0]  data, a, b;
        logic [3:0]  fun;
        logic        stall, stray;
        logic [1:0]  nrx;
        logic [7:0]  rx0, rx1, gap0, gap1;
        logic [2:0]  nfr;
        logic [31:0] fr;
        logic [15:0] rsp;
        logic        tmo;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask

    function automatic vec_t stim(input logic [1:0] cmd, input logic [3:0] addr,
                                  input logic [7:0] data, a, b, input logic [3:0] fun,
                                  input logic stall, stray, input logic [1:0] nrx,
                                  input logic [7:0] rx0, rx1, gap0, gap1);
        vec_t v;
        v = '0;
        v.cmd = cmd; v.addr = addr; v.data = data; v.a = a; v.b = b; v.fun = fun;
        v.stall = stall; v.stray = stray; v.nrx = nrx;
        v.rx0 = rx0; v.rx1 = rx1; v.gap0 = gap0; v.gap1 = gap1;
        return v;
    endfunction

    function automatic vec_t dv(input vec_t s, input logic [2:0] nfr, input logic [31:0] fr,
                                input logic [15:0] rsp, input logic tmo);
        vec_t v;
        v = s; v.nfr = nfr; v.fr = fr; v.rsp = rsp; v.tmo = tmo;
        return v;
    endfunction

    // Reference: frame list and expected response straight from the protocol tables.
    function automatic vec_t model(input vec_t s);
        vec_t v;
        logic [7:0] q[$];
        int e;
        v = s;
        case (s.cmd)
            2'b00: begin q = '{8'hAA, {4'h0, s.addr}, s.data}; e = 0; end
            2'b01: begin q = '{8'hBB, {4'h0, s.addr}}; e = 1; end
            2'b10: begin q = '{8'hCC, s.a, s.b, {4'h0, s.fun}}; e = 2; end
            default: begin q = '{8'hDD, {4'h0, s.fun}}; e = 2; end
        endcase
        v.nfr = 3'(q.size());
        v.fr = '0;
        foreach (q[i]) v.fr[31-8*i -: 8] = q[i];
        v.rsp = '0;
        if (e >= 1 && s.nrx >= 1) v.rsp[7:0] = s.rx0;
        if (e >= 2 && s.nrx >= 2) v.rsp[15:8] = s.rx1;
        v.tmo = int'(s.nrx) < e;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        logic [7:0] got[$];
        int cyc, last_ev, next_rx, rsp_cyc, first_tx, last_tx, sent;
        bit txdone, seen, pend;
        logic [7:0] pd;
        logic [15:0] r_data;
        logic r_tmo, r_busy, r_rdy;
        if (v.stray) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = 8'hEE;
            @(negedge clk); rx_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_cmd = v.cmd; req_addr = v.addr; req_data = v.data;
        req_op_a = v.a; req_op_b = v.b; req_fun = v.fun;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 2'($urandom); req_addr = 4'($urandom); req_data = 8'($urandom);
        req_op_a = 8'($urandom); req_op_b = 8'($urandom); req_fun = 4'($urandom);
        cyc = 0; last_ev = 0; next_rx = -1; rsp_cyc = -1; first_tx = -1; last_tx = -1;
        sent = 0; txdone = 0; seen = 0; pend = 0; pd = '0;
        r_data = '0; r_tmo = 0; r_busy = 0; r_rdy = 1;
        while (!seen && cyc < 200) begin
            rx_valid = 1'b0;
            if (rsp_valid) begin
                seen = 1; rsp_cyc = cyc; r_data = rsp_data; r_tmo = rsp_timeout;
                r_busy = busy; r_rdy = req_ready;
            end else begin
                if (pend) begin
                    chk({tag, " stall_valid"}, 32'(tx_valid), 32'd1);
                    chk({tag, " stall_data"}, 32'(tx_data), 32'(pd));
                end
                tx_ready = v.stall ? (cyc % 2 == 0) : 1'b1;
                pend = tx_valid && !tx_ready;
                pd = tx_data;
                if (tx_valid && tx_ready) begin
                    if (first_tx < 0) first_tx = cyc;
                    last_tx = cyc;
                    got.push_back(tx_data);
                    if (got.size() == int'(v.nfr)) begin
                        txdone = 1; last_ev = cyc; next_rx = cyc + int'(v.gap0);
                    end
                end
                if (txdone && sent < int'(v.nrx) && cyc == next_rx) begin
                    rx_valid = 1'b1;
                    rx_data = sent == 0 ? v.rx0 : v.rx1;
                    sent++; last_ev = cyc; next_rx = cyc + int'(v.gap1);
                end
                @(negedge clk);
                cyc++;
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk({tag, " rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, " frame_count"}, 32'(got.size()), 32'(v.nfr));
        for (int i = 0; i < int'(v.nfr) && i < got.size(); i++)
            chk($sformatf("%s frame%0d", tag, i), 32'(got[i]), 32'(v.fr[31-8*i -: 8]));
        if (!v.stall) begin
            chk({tag, " first_frame_cycle"}, 32'(first_tx), 32'd0);
            chk({tag, " frame_span"}, 32'(last_tx - first_tx), 32'(int'(v.nfr) - 1));
        end
        if (seen) begin
            chk({tag, " rsp_data"}, 32'(r_data), 32'(v.rsp));
            chk({tag, " rsp_timeout"}, 32'(r_tmo), 32'(v.tmo));
            chk({tag, " busy_at_rsp"}, 32'(r_busy), 32'd1);
            chk({tag, " ready_at_rsp"}, 32'(r_rdy), 32'd0);
            chk({tag, " rsp_latency"}, 32'(rsp_cyc - last_ev), v.tmo ? 32'd16 : 32'd1);
            @(negedge clk);
            chk({tag, " rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
            chk({tag, " idle_after"}, {30'd0, req_ready, busy}, 32'd2);
            chk({tag, " rsp_held"}, 32'(rsp_data), 32'(v.rsp));
        end
    endtask

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        tbl[0] = dv(stim(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 2'd0, 8'h00, 8'h00, 8'd1, 8'd1),
                    3'd3, 32'hAA053C00, 16'h0000, 1'b0);
        tbl[1] = dv(stim(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 2'd1, 8'h81, 8'h00, 8'd3, 8'd1),
                    3'd2, 32'hBB020000, 16'h0081, 1'b0);
        tbl[2] = dv(stim(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h2, 1, 0, 2'd2, 8'h00, 8'h02, 8'd2, 8'd3),
                    3'd4, 32'hCC102002, 16'h0200, 1'b0);
        tbl[3] = dv(stim(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h8, 0, 0, 2'd1, 8'h55, 8'h00, 8'd2, 8'd1),
                    3'd2, 32'hDD080000, 16'h0055, 1'b1);
        tbl[4] = dv(stim(2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 2'd1, 8'h11, 8'h00, 8'd4, 8'd1),
                    3'd2, 32'hBB070000, 16'h0011, 1'b0);
        tbl[5] = dv(stim(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 2'd1, 8'h99, 8'h00, 8'd15, 8'd1),
                    3'd2, 32'hBB0F0000, 16'h0099, 1'b0);
        tbl[6] = dv(stim(2'b10, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 0, 0, 2'd2, 8'h34, 8'h12, 8'd1, 8'd15),
                    3'd4, 32'hCCFF010F, 16'h1234, 1'b0);
        tbl[7] = dv(stim(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1, 0, 2'd0, 8'h00, 8'h00, 8'd1, 8'd1),
                    3'd2, 32'hDD000000, 16'h0000, 1'b1);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {25'd0, req_ready, tx_valid, rsp_valid, rsp_timeout, busy, 2'b00}, 32'h40);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("dir%0d", i));

        // Reset in the middle of an ALU request's second frame.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b10; req_op_a = 8'h10; req_op_b = 8'h20; req_fun = 4'h2;
        tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid second_frame", {23'd0, tx_valid, tx_data}, 32'h110);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid state", {29'd0, tx_valid, req_ready, rsp_valid}, 32'd2);
        begin
            int saw = 0;
            repeat (20) begin
                @(negedge clk);
                if (rsp_valid || tx_valid) saw++;
            end
            chk("rst_mid silent", 32'(saw), 32'd0);
        end
        run(model(stim(2'b00, 4'h9, 8'hA5, 8'h00, 8'h00, 4'h0, 0, 0, 2'd0, 8'h00, 8'h00, 8'd1, 8'd1)), "post_rst_wr");

        for (int i = 0; i < 40; i++) begin
            logic [1:0] cmd;
            int e;
            cmd = 2'($urandom_range(0, 3));
            e = cmd == 2'b00 ? 0 : cmd == 2'b01 ? 1 : 2;
            run(model(stim(cmd, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, e)),
                           8'($urandom), 8'($urandom), 8'($urandom_range(1, 12)), 8'($urandom_range(1, 12)))),
                $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
